// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider, signed/unsigned quotient or remainder, with fast paths for /0 and overflow.
module iter_divider #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          op,
  input  logic [DATA_LEN-1:0] src_a,
  input  logic [DATA_LEN-1:0] src_b,
  input  logic                kill,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] result,
  output logic                busy
);
  localparam int CW = DATA_LEN > 1 ? $clog2(DATA_LEN) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DATA_LEN-1:0] quo, dvs, a_abs, b_abs, quo_nxt, q_fin, r_fin;
  logic [DATA_LEN:0] rem, rem_sh, trial, rem_nxt;
  logic sel_rem, q_neg, r_neg;
  logic signed_op, a_neg, b_neg, div_zero, ovf, fast, accept, last;
  always_comb begin
    signed_op = ~op[0];
    a_neg = signed_op & src_a[DATA_LEN-1];
    b_neg = signed_op & src_b[DATA_LEN-1];
    a_abs = a_neg ? -src_a : src_a;
    b_abs = b_neg ? -src_b : src_b;
    div_zero = src_b == '0;
    ovf = signed_op && src_a == {1'b1, {(DATA_LEN-1){1'b0}}} && &src_b;
    fast = div_zero | ovf;
    req_ready = state == IDLE;
    resp_valid = state == DONE;
    busy = state != IDLE;
    accept = req_valid && req_ready && !kill;
    last = cnt == CW'(DATA_LEN-1);
    rem_sh = {rem[DATA_LEN-1:0], quo[DATA_LEN-1]};
    trial = rem_sh - {1'b0, dvs};
    rem_nxt = trial[DATA_LEN] ? rem_sh : trial;
    quo_nxt = {quo[DATA_LEN-2:0], ~trial[DATA_LEN]};
    q_fin = q_neg ? -quo_nxt : quo_nxt;
    r_fin = r_neg ? -rem_nxt[DATA_LEN-1:0] : rem_nxt[DATA_LEN-1:0];
    state_nxt = kill ? IDLE :
                state == IDLE ? (req_valid ? (fast ? DONE : CALC) : IDLE) :
                state == CALC ? (last ? DONE : CALC) :
                (resp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      quo <= '0;
      dvs <= '0;
      rem <= '0;
      sel_rem <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        quo <= a_abs;
        dvs <= b_abs;
        rem <= '0;
        sel_rem <= op[1];
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        if (fast) result <= op[1] ? (div_zero ? src_a : '0) : (div_zero ? '1 : src_a);
      end else if (state == CALC && !kill) begin
        cnt <= last ? cnt : cnt + CW'(1);
        quo <= quo_nxt;
        rem <= rem_nxt;
        if (last) result <= sel_rem ? r_fin : q_fin;
      end
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed and random checks of iter_divider against an arithmetic reference model.
module tb_iter_divider;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, kill = 1'b0, resp_ready = 1'b0;
  logic [1:0] op = '0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic req_ready, resp_valid, busy;
  logic [W-1:0] result;
  int errors = 0, checks = 0;
  iter_divider #(.DATA_LEN(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .kill(kill), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .result(result), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return o[1] ? a : '1;
    if (!o[0] && a == 32'h8000_0000 && b == '1) return o[1] ? '0 : a;
    case (o)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction
  function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0 || (!o[0] && a == 32'h8000_0000 && b == '1)) ? 1 : W + 1;
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
  endtask
  task automatic wait_resp(input logic [W-1:0] exp, input int exp_lat, input string tag);
    int lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk(tag, result, exp);
  endtask
  task automatic ack(input string tag);
    logic [W-1:0] r = result;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_ack_valid"}, {31'd0, resp_valid}, 0);
    chk({tag, "_ack_ready"}, {31'd0, req_ready}, 1);
    chk({tag, "_ack_hold"}, result, r);
  endtask
  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    start(o, a, b);
    @(negedge clk);
    req_valid = 1'b0;
    op = 2'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    wait_resp(model(o, a, b), lat_of(o, a, b), tag);
    ack(tag);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [W-1:0] held, ra, rb;
    logic seen;
    logic [1:0] ro;
    #2;
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_valid", {31'd0, resp_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    run(2'd1, 100, 7, "divu_100_7");
    run(2'd3, 100, 7, "remu_100_7");
    run(2'd0, 32'hFFFF_FFF9, 2, "div_m7_2");
    run(2'd2, 32'hFFFF_FFF9, 2, "rem_m7_2");
    run(2'd1, 5, 0, "divu_5_0");
    run(2'd3, 5, 0, "remu_5_0");
    run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run(2'd0, 5, 0, "div_5_0");
    run(2'd2, 32'h8000_0000, 3, "rem_min_3");
    // back-pressure: hold result 10 cycles while a new request waits
    start(2'd0, 32'hFFFF_FFF9, 2);
    @(negedge clk);
    wait_resp(32'hFFFF_FFFD, W + 1, "hold_div");
    held = result;
    start(2'd1, 100, 7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 1);
      chk("hold_result", result, held);
      chk("hold_ready", {31'd0, req_ready}, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hs_valid", {31'd0, resp_valid}, 0);
    chk("hs_busy", {31'd0, busy}, 0);
    chk("hs_result", result, held);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hs_accept_busy", {31'd0, busy}, 1);
    wait_resp(14, W + 1, "hs_next");
    ack("hs_next");
    // kill during iteration 10
    start(2'd1, 32'h1234_5678, 3);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 0);
    chk("kill_ready", {31'd0, req_ready}, 1);
    chk("kill_result", result, 14);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    chk("kill_no_resp", {31'd0, seen}, 0);
    // asynchronous reset mid-calculation
    start(2'd0, 32'hDEAD_BEEF, 32'h0000_0123);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_ready", {31'd0, req_ready}, 1);
    chk("arst_valid", {31'd0, resp_valid}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    run(2'd1, 9, 3, "post_rst");
    // random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: rb = $urandom_range(1, 15);
        3: rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run(ro, ra, rb, $sformatf("rnd%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: operand and result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  divide request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port src_a  input  DATA_LEN  dividend, taken from the ALU A-operand mux output.
REQ-008 SHALL have port src_b  input  DATA_LEN  divisor, taken from the ALU B-operand mux output.
REQ-009 SHALL have port kill  input  1  abort any in-flight operation.
REQ-010 SHALL have port resp_valid  output  1  result available.
REQ-011 SHALL have port resp_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  DATA_LEN  quotient or remainder, per latched op.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; req_ready = (state==IDLE); resp_valid = (state==DONE).
REQ-015 SHALL accept a request when req_valid && req_ready && !kill at a rising edge; op, src_a and src_b are latched on that edge and later input changes have no effect.
REQ-016 SHALL, on acceptance with divisor==0, go to DONE next cycle: quotient = all ones, remainder = dividend (signed and unsigned).
REQ-017 SHALL, on acceptance of signed op with dividend==most-negative and divisor==all ones, go to DONE next cycle: quotient = dividend, remainder = 0.
REQ-018 SHALL otherwise enter CALC with iteration counter 0; signed ops operate on absolute values.
REQ-019 SHALL perform one restoring shift-subtract step per CALC cycle, using a DATA_LEN+1-bit partial remainder; counter wraps never, exit at count==DATA_LEN-1.
REQ-020 SHALL transition CALC->DONE after exactly DATA_LEN iterations; normal-path resp_valid first high in cycle T+DATA_LEN+1 for acceptance in cycle T; fast path (REQ-016/017) in cycle T+1.
REQ-021 SHALL register the final result on entry to DONE: signed quotient negated when operand signs differ; signed remainder takes dividend's sign; REM/REMU select remainder, DIV/DIVU quotient.
REQ-022 SHALL hold result and resp_valid stable in DONE while resp_ready is low, for any number of cycles.
REQ-023 SHALL return DONE->IDLE on the edge where resp_ready is high; no request accepted in that same cycle (req_ready low in DONE); earliest next acceptance is the following cycle.
REQ-024 SHALL, when kill is high at an edge, force IDLE regardless of state; kill has priority over acceptance and over the response handshake; no resp_valid is produced for the killed operation.
REQ-025 SHALL keep result unchanged outside DONE (last value held) and never glitch resp_valid.

Reset
REQ-026 SHALL, on reset low, immediately set state IDLE, counter 0, result 0, internal operand/remainder registers 0; thus req_ready=1, resp_valid=0, busy=0.
REQ-027 SHALL abandon any in-flight operation on reset with no response, and accept a new request on the first edge after reset deasserts.

Verification
REQ-028 SHALL cover: DIVU src_a=100, src_b=7 accepted cycle T -> resp_valid at T+33, result 14; repeat with REMU -> 2.
REQ-029 SHALL cover: DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-030 SHALL cover: DIVU 5/0 -> result 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both at T+1.
REQ-031 SHALL cover: resp_ready held low 10 cycles in DONE -> result and resp_valid stable; req_valid asserted throughout not accepted until the cycle after handshake.
REQ-032 SHALL cover: kill pulsed at CALC iteration 10 -> IDLE next cycle, no resp_valid; reset asserted mid-CALC -> outputs at reset values immediately, fresh DIVU 9/3 afterwards -> 3.
